pi_compensator: RTL
===================

PI_COMPENSATOR -- requirements
Module: pi_compensator

Interface
REQ-001 Parameter KP, 16, proportional gain, signed 8-bit integer, scaled by 2^-FRAC.
REQ-002 Parameter KI, 4, integral gain, signed 8-bit integer, scaled by 2^-FRAC.
REQ-003 Parameter FRAC, 8, number of fractional bits in the gain/accumulator format.
REQ-004 Parameter DUTY_MIN, 0, lower duty-count clamp.
REQ-005 Parameter DUTY_INIT, 161, duty count applied at reset and while disabled.
REQ-006 CLOCK_50  input  1  50 MHz system clock; all state updates on rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 EN  input  1  compensator enable; low = hold at DUTY_INIT.
REQ-009 sample_valid  input  1  one-cycle strobe: err carries a new ADC error sample.
REQ-010 err  input  13  signed two's-complement error (Vref - Vout) in ADC LSBs.
REQ-011 maxcount  input  10  unsigned DPWM period count; upper duty clamp.
REQ-012 duty_out  output  10  unsigned duty count for the adjust-duty/DPWM stage; registered.
REQ-013 duty_valid  output  1  one-cycle pulse when duty_out updates.
REQ-014 sat_hi  output  1  last result clamped at maxcount.
REQ-015 sat_lo  output  1  last result clamped at DUTY_MIN.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, PROP, INTEG, SUM, SAT, OUT; one state per clock.
REQ-018 IDLE -> PROP on sample_valid=1 with EN=1; err is captured into an internal register on that edge.
REQ-019 PROP: p = KP*err_reg, 21-bit signed, full precision.
REQ-020 INTEG: acc = acc + KI*err_reg (24-bit signed accumulator), then clamp acc to [DUTY_MIN<<FRAC, maxcount<<FRAC] (anti-windup).
REQ-021 SUM: s = acc + sign-extended p, 25-bit signed, no overflow possible.
REQ-022 SAT: u = s >>> FRAC (arithmetic shift, floor). If u > maxcount: result = maxcount, sat_hi=1. If u < DUTY_MIN: result = DUTY_MIN, sat_lo=1. Otherwise result = u and both flags 0.
REQ-023 OUT: duty_out <= result and duty_valid=1 for exactly this cycle; next state IDLE.
REQ-024 Latency: duty_valid is asserted 5 clocks after the edge that accepts sample_valid; sustained throughput is 1 sample per 6 clocks.
REQ-025 sample_valid while busy=1 is dropped, with no queueing and no effect on err_reg.
REQ-026 maxcount is sampled in INTEG and SAT only; changes at other times take effect on the next sample.
REQ-027 EN=0 in any state: next state IDLE, acc <= DUTY_INIT<<FRAC, duty_out <= DUTY_INIT, flags cleared, and no duty_valid, including when EN falls during OUT.
REQ-028 The EN 0->1 transition has no effect until the next sample_valid.
REQ-029 If DUTY_INIT > maxcount, the first processed sample clamps the result to maxcount (REQ-020/022); no special case.

Reset
REQ-030 When resetn=0, immediately and asynchronously: state=IDLE, err_reg=0, acc=DUTY_INIT<<FRAC, duty_out=DUTY_INIT, duty_valid=0, sat_hi=0, sat_lo=0, busy=0.
REQ-031 Reset during an in-flight computation discards that computation, and no duty_valid follows.
REQ-032 Outputs are valid from the first rising edge after resetn rises.

Verification (KP=16, KI=4, FRAC=8, DUTY_MIN=0, DUTY_INIT=161, maxcount=322)
REQ-033 Reset, then release -> duty_out=161, acc=41216, busy=0, flags 0.
REQ-034 One sample, err=+10 -> acc=41256, s=41416, duty_out=161, duty_valid exactly 5 clocks after the strobe, busy high for 5 clocks.
REQ-035 Repeated err=+4095 strobes -> acc clamps at 82432, duty_out=322, sat_hi=1; then a single err=-1 sample -> acc=82428, s=82412, duty_out=321, sat_hi=0 (windup does not delay recovery).
REQ-036 Sequence from reset:
- err=-4096 -> acc=24832, s=-40704, u=-159, duty_out=0, sat_lo=1.
- err=0 -> duty_out=97.
REQ-037 Strobes every 2 clocks -> only every third strobe is processed; EN dropped during SUM -> no duty_valid, duty_out=161 the next clock.
REQ-038 resetn pulsed low during SAT -> duty_out=161 immediately and no duty_valid pulse follows.

Source files
------------

// File: rtl/pi_compensator.sv
// Digital PI compensator for a DPWM buckconverter loop.
// Each accepted error sample walks through a six-state pipeline
// (IDLE, PROP, INTEG, SUM, SAT, OUT) and produces one clamped duty count.
// The integrator is clamped to the duty range so that it cannot wind up.

module pi_compensator #(
    parameter logic signed [7:0] KP        = 8'sd16,
    parameter logic signed [7:0] KI        = 8'sd4,
    parameter int                FRAC      = 8,
    parameter int                DUTY_MIN  = 0,
    parameter int                DUTY_INIT = 161
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               EN,
    input  logic               sample_valid,
    input  logic signed [12:0] err,
    input  logic        [9:0]  maxcount,
    output logic        [9:0]  duty_out,
    output logic               duty_valid,
    output logic               sat_hi,
    output logic               sat_lo,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        PROP,
        INTEG,
        SUM,
        SAT,
        OUT
    } stateT;

    localparam logic signed [20:0] KP_EXT      = 21'(KP);
    localparam logic signed [20:0] KI_EXT      = 21'(KI);
    localparam logic signed [23:0] ACC_INIT    = 24'(DUTY_INIT <<< FRAC);
    localparam logic signed [24:0] ACC_LO      = 25'(DUTY_MIN <<< FRAC);
    localparam logic signed [24:0] DUTY_MIN_EX = 25'(DUTY_MIN);
    localparam logic        [9:0]  DUTY_MIN_C  = 10'(DUTY_MIN);
    localparam logic        [9:0]  DUTY_INIT_C = 10'(DUTY_INIT);

    stateT state_q, state_d;

    logic signed [12:0] err_q;
    logic signed [20:0] prop_q;
    logic signed [23:0] acc_q;
    logic signed [24:0] sum_q;
    logic        [9:0]  result_q;
    logic               resHi_q;
    logic               resLo_q;
    logic        [9:0]  duty_q;
    logic               dutyValid_q;
    logic               satHi_q;
    logic               satLo_q;

    logic signed [20:0] errExt;
    logic signed [20:0] propProd;
    logic signed [20:0] integProd;
    logic signed [24:0] accSum;
    logic signed [24:0] accHi;
    logic signed [23:0] accNext;
    logic signed [24:0] sumNext;
    logic signed [24:0] uFull;
    logic signed [24:0] maxExt;
    logic        [9:0]  resultNext;
    logic               resHiNext;
    logic               resLoNext;

    // State register; reset drops any computation in flight.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one pipeline step per clock, EN low forces IDLE.
    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sample_valid) state_d = PROP;
                PROP:    state_d = INTEG;
                INTEG:   state_d = SUM;
                SUM:     state_d = SAT;
                SAT:     state_d = OUT;
                OUT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: busy tracks the pipeline, the rest come from registers.
    always_comb begin
        busy       = (state_q != IDLE);
        duty_out   = duty_q;
        duty_valid = dutyValid_q;
        sat_hi     = satHi_q;
        sat_lo     = satLo_q;
    end

    // Arithmetic for each pipeline stage, including anti-windup and output clamps.
    always_comb begin
        errExt     = {{8{err_q[12]}}, err_q};
        propProd   = KP_EXT * errExt;
        integProd  = KI_EXT * errExt;
        accSum     = {acc_q[23], acc_q} + {{4{integProd[20]}}, integProd};
        accHi      = {15'd0, maxcount} << FRAC;
        accNext    = accSum[23:0];
        if (accSum > accHi) begin
            accNext = accHi[23:0];
        end else if (accSum < ACC_LO) begin
            accNext = ACC_LO[23:0];
        end
        sumNext    = {acc_q[23], acc_q} + {{4{prop_q[20]}}, prop_q};
        uFull      = sum_q >>> FRAC;
        maxExt     = {15'd0, maxcount};
        resultNext = uFull[9:0];
        resHiNext  = 1'b0;
        resLoNext  = 1'b0;
        if (uFull > maxExt) begin
            resultNext = maxcount;
            resHiNext  = 1'b1;
        end else if (uFull < DUTY_MIN_EX) begin
            resultNext = DUTY_MIN_C;
            resLoNext  = 1'b1;
        end
    end

    // Datapath registers advanced by the current state; EN low restores the initial duty.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            err_q       <= '0;
            prop_q      <= '0;
            acc_q       <= ACC_INIT;
            sum_q       <= '0;
            result_q    <= DUTY_INIT_C;
            resHi_q     <= 1'b0;
            resLo_q     <= 1'b0;
            duty_q      <= DUTY_INIT_C;
            dutyValid_q <= 1'b0;
            satHi_q     <= 1'b0;
            satLo_q     <= 1'b0;
        end else if (!EN) begin
            acc_q       <= ACC_INIT;
            duty_q      <= DUTY_INIT_C;
            dutyValid_q <= 1'b0;
            satHi_q     <= 1'b0;
            satLo_q     <= 1'b0;
            resHi_q     <= 1'b0;
            resLo_q     <= 1'b0;
        end else begin
            dutyValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        err_q <= err;
                    end
                end
                PROP: begin
                    prop_q <= propProd;
                end
                INTEG: begin
                    acc_q <= accNext;
                end
                SUM: begin
                    sum_q <= sumNext;
                end
                SAT: begin
                    result_q <= resultNext;
                    resHi_q  <= resHiNext;
                    resLo_q  <= resLoNext;
                end
                OUT: begin
                    duty_q      <= result_q;
                    satHi_q     <= resHi_q;
                    satLo_q     <= resLo_q;
                    dutyValid_q <= 1'b1;
                end
                default: begin
                    dutyValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
